// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the iCE40 PLL lock sequencer.
package pll_seq_pkg;

   localparam int unsigned STATE_W    = 3;
   localparam int unsigned LOSS_CNT_W = 8;

   typedef enum logic [STATE_W-1:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_state_e;

   // Largest of three cycle counts; sizes the shared state counter.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_ice40_prim.sv
// iCE40 PLL wrapper: PAD or CORE primitive for synthesis, behavioural stand-in for simulation.
module pll_ice40_prim #(
   parameter bit          ICE40_PAD       = 1'b0,
   parameter logic [3:0]  DIVR            = 4'd0,
   parameter logic [6:0]  DIVF            = 7'd83,
   parameter logic [2:0]  DIVQ            = 3'd3,
   parameter logic [2:0]  FILTER_RANGE    = 3'd1,
   parameter int unsigned SIM_LOCK_CYCLES = 5
) (
   input  logic refclk,
   input  logic resetb,
   output logic lock,
   output logic clkout
);

`ifdef SYNTHESIS
   if (ICE40_PAD) begin : g_pad
      SB_PLL40_PAD #(
         .FEEDBACK_PATH ("SIMPLE"),
         .DIVR          (DIVR),
         .DIVF          (DIVF),
         .DIVQ          (DIVQ),
         .FILTER_RANGE  (FILTER_RANGE)
      ) u_pll (
         .PACKAGEPIN (refclk),
         .PLLOUTCORE (clkout),
         .RESETB     (resetb),
         .BYPASS     (1'b0),
         .LOCK       (lock)
      );
   end else begin : g_core
      SB_PLL40_CORE #(
         .FEEDBACK_PATH ("SIMPLE"),
         .DIVR          (DIVR),
         .DIVF          (DIVF),
         .DIVQ          (DIVQ),
         .FILTER_RANGE  (FILTER_RANGE)
      ) u_pll (
         .REFERENCECLK (refclk),
         .PLLOUTCORE   (clkout),
         .RESETB       (resetb),
         .BYPASS       (1'b0),
         .LOCK         (lock)
      );
   end
`else
   // Model: lock asserts SIM_LOCK_CYCLES refclk cycles after RESETB rises, drops while in reset.
   localparam logic [7:0] LOCK_AT = 8'(SIM_LOCK_CYCLES);

   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic       unused_cfg;

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (!resetb) begin
         lock_cnt_d = '0;
      end else if (lock_cnt_q != LOCK_AT) begin
         lock_cnt_d = lock_cnt_q + 8'(1);
      end
   end

   always_ff @(posedge refclk) begin
      lock_cnt_q <= lock_cnt_d;
   end

   assign lock       = (lock_cnt_q == LOCK_AT);
   assign clkout     = refclk;
   assign unused_cfg = ^{ICE40_PAD, DIVR, DIVF, DIVQ, FILTER_RANGE};
`endif

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for debounced lock with timeout/retry,
// and releases a downstream reset request once the PLL is stable.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter bit          ICE40_PAD           = 1'b0,
   parameter logic [3:0]  DIVR                = 4'd0,
   parameter logic [6:0]  DIVF                = 7'd83,
   parameter logic [2:0]  DIVQ                = 3'd3,
   parameter logic [2:0]  FILTER_RANGE        = 3'd1,
   parameter int unsigned RESET_CYCLES        = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                  clock_in,
   input  logic                  reset,
   input  logic                  restart,
   output logic                  clock_out,
   output logic                  pll_ready,
   output logic                  rst_out,
   output logic                  fail,
   output logic [LOSS_CNT_W-1:0] lock_loss_count,
   output logic [STATE_W-1:0]    state
);

   localparam int unsigned MAX_CYC = max3(RESET_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned RTRY_W  = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRIES);

   pll_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [RTRY_W-1:0]     retries_q, retries_d;
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;
   logic                  lock_meta_q, lock_meta_d;
   logic                  lock_s_q, lock_s_d;
   logic                  ready_q, ready_d;
   logic                  rst_out_q, rst_out_d;
   logic                  fail_q, fail_d;
   logic                  resetb_q, resetb_d;
   logic                  pll_lock;

   pll_ice40_prim #(
      .ICE40_PAD    (ICE40_PAD),
      .DIVR         (DIVR),
      .DIVF         (DIVF),
      .DIVQ         (DIVQ),
      .FILTER_RANGE (FILTER_RANGE)
   ) u_pll (
      .refclk (clock_in),
      .resetb (resetb_q),
      .lock   (pll_lock),
      .clkout (clock_out)
   );

   // Next-state, counters and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      retries_d   = retries_q;
      loss_d      = loss_q;
      lock_meta_d = pll_lock;
      lock_s_d    = lock_meta_q;

      unique case (state_q)
         RESET: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TMO_LAST) begin
               retries_d = retries_q + RTRY_W'(1);
               cnt_d     = '0;
               state_d   = (retries_q + RTRY_W'(1) == RTRY_MAX) ? FAIL : RESET;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d   = RUN;
               cnt_d     = '0;
               retries_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_s_q) begin
               state_d = RESET;
               cnt_d   = '0;
               if (loss_q != '1) begin
                  loss_d = loss_q + LOSS_CNT_W'(1);
               end
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = RESET;
            cnt_d   = '0;
         end
      endcase

      // Restart overrides the transition but a simultaneous lock loss is still counted.
      if (restart) begin
         state_d = RESET;
         cnt_d   = '0;
         if (state_q == FAIL) begin
            retries_d = '0;
         end
      end

      ready_d   = (state_d == RUN);
      rst_out_d = (state_d != RUN);
      fail_d    = (state_d == FAIL);
      resetb_d  = (state_d inside {WAIT_LOCK, STABLE, RUN});
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q     <= RESET;
         cnt_q       <= '0;
         retries_q   <= '0;
         loss_q      <= '0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         ready_q     <= 1'b0;
         rst_out_q   <= 1'b1;
         fail_q      <= 1'b0;
         resetb_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retries_q   <= retries_d;
         loss_q      <= loss_d;
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         ready_q     <= ready_d;
         rst_out_q   <= rst_out_d;
         fail_q      <= fail_d;
         resetb_q    <= resetb_d;
      end
   end

   assign pll_ready       = ready_q;
   assign rst_out         = rst_out_q;
   assign fail            = fail_q;
   assign lock_loss_count = loss_q;
   assign state           = state_q;

endmodule
